// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// load/store. One transaction is outstanding at a time. The response is routed
// back to the requester that owns the transaction.
//
// Build option: MEMARB_RR_EN. When it is defined, ties are broken round-robin.
// When it is undefined (default), data has fixed priority and a starvation
// guard protects fetch.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   i_req/i_addr         fetch request (held until i_gnt)
//   i_gnt/i_rvalid       fetch accept pulse / fetch data valid pulse
//   i_rdata              fetched word
//   d_req/d_we/d_wstrb   data request, store flag, byte enables
//   d_addr/d_wdata       data address / store data
//   d_gnt/d_rvalid       data accept pulse / load data valid or store done pulse
//   d_rdata              load data
//   m_req..m_wdata       memory request channel (accepted on m_req && m_ready)
//   m_ready              memory accepts the request
//   m_rvalid/m_rdata     memory response / read data
//   busy                 arbiter not idle
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,

   output logic        busy
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam logic        OWN_FETCH = 1'b0;
   localparam logic        OWN_DATA  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic            owner_q;
   logic [AW-1:0]   addr_q;
   logic            we_q;
   logic [SW-1:0]   wstrb_q;
   logic [DW-1:0]   wdata_q;

   logic            pick_valid;
   logic            pick_fetch;
   logic            accept;

`ifdef MEMARB_RR_EN
   logic            last_owner_q;
`else
   localparam int unsigned CW = 4;
   logic [CW-1:0]   starve_cnt_q;
`endif

   // Arbitration: decide who would be selected if the FSM is idle.
   always_comb begin
      pick_valid = i_req | d_req;
      pick_fetch = 1'b0;
      if (i_req && !d_req) begin
         pick_fetch = 1'b1;
      end else if (i_req && d_req) begin
`ifdef MEMARB_RR_EN
         pick_fetch = (last_owner_q == OWN_DATA);
`else
         pick_fetch = (starve_cnt_q == CW'(STARVE_MAX));
`endif
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_valid) state_d = S_ISSUE;
         S_ISSUE: if (m_ready)    state_d = S_WAIT;
         S_WAIT:  if (m_rvalid)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs. Grants are combinational from m_ready so the requester sees the
   // accept in the same cycle. Everything is gated by rstn so that nothing
   // pulses while reset is being applied.
   always_comb begin
      m_req   = rstn && (state_q == S_ISSUE);
      accept  = m_req && m_ready;
      i_gnt   = accept && (owner_q == OWN_FETCH);
      d_gnt   = accept && (owner_q == OWN_DATA);
      busy    = rstn && (state_q != S_IDLE);
      m_we    = we_q;
      m_wstrb = wstrb_q;
      m_addr  = addr_q;
      m_wdata = wdata_q;
   end

   // Request latch: m_* come only from here, so they stay stable during stalls.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         owner_q <= OWN_FETCH;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else if (state_q == S_IDLE && pick_valid) begin
         if (pick_fetch) begin
            owner_q <= OWN_FETCH;
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
         end else begin
            owner_q <= OWN_DATA;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wstrb_q <= d_wstrb;
            wdata_q <= d_wdata;
         end
      end
   end

   // Response routing: register read data and pulse the owner's rvalid.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         if (state_q == S_WAIT && m_rvalid) begin
            if (owner_q == OWN_FETCH) begin
               i_rvalid <= 1'b1;
               i_rdata  <= m_rdata;
            end else begin
               d_rvalid <= 1'b1;
               // A store ack carries no data, so d_rdata keeps its last load value.
               if (!we_q) d_rdata <= m_rdata;
            end
         end
      end
   end

`ifdef MEMARB_RR_EN
   // Last granted requester; the other one wins the next tie.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_owner_q <= OWN_FETCH;
      end else if (i_gnt) begin
         last_owner_q <= OWN_FETCH;
      end else if (d_gnt) begin
         last_owner_q <= OWN_DATA;
      end
   end
`else
   // Starvation guard: count data grants that bypass a waiting fetch.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_cnt_q <= '0;
      end else if (i_gnt) begin
         starve_cnt_q <= '0;
      end else if (d_gnt && i_req && (starve_cnt_q < CW'(STARVE_MAX))) begin
         starve_cnt_q <= starve_cnt_q + CW'(1);
      end
   end
`endif

endmodule
